tx_framer: RTL and testbench

TX_FRAMER -- requirements
Module: tx_framer

---
 rtl/tx_framer.sv | 128 ++++++++++++
 tb/tb_tx_framer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
// Wraps a payload byte stream into frames: SOF marker, payload bytes, then a
// checksum byte making the payload plus checksum sum to zero modulo 2^DATA_WIDTH.
module tx_framer #(
  parameter int unsigned            DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0]  SOF_BYTE   = 8'hA5,
  parameter logic [15:0]            MAX_LEN    = 16'd4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_rdy,
  input  logic                  in_eof,
  output logic                  in_ack,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_rdy,
  input  logic                  tx_ack,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  len_err
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD,
    CHECKSUM
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_rdy_q, tx_rdy_d;
  logic                  eof_q, eof_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic                  len_err_q, len_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_data_q   <= '0;
      tx_rdy_q    <= 1'b0;
      eof_q       <= 1'b0;
      sum_q       <= '0;
      len_q       <= '0;
      frame_cnt_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_rdy_q    <= tx_rdy_d;
      eof_q       <= eof_d;
      sum_q       <= sum_d;
      len_q       <= len_d;
      frame_cnt_q <= frame_cnt_d;
      len_err_q   <= len_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_rdy_d    = tx_rdy_q;
    eof_d       = eof_q;
    sum_d       = sum_q;
    len_d       = len_q;
    frame_cnt_d = frame_cnt_q;
    len_err_d   = len_err_q;
    in_ack      = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_rdy) begin
          state_d   = HEADER;
          tx_data_d = SOF_BYTE;
          tx_rdy_d  = 1'b1;
        end
      end
      HEADER: begin
        if (tx_ack) begin
          state_d  = PAYLOAD;
          tx_rdy_d = 1'b0;
          eof_d    = 1'b0;
          sum_d    = '0;
          len_d    = '0;
        end
      end
      PAYLOAD: begin
        if (!tx_rdy_q) begin
          if (in_rdy) begin
            // Ack is masked during reset so the source never drops a byte
            // that the framer is about to forget.
            in_ack    = !rst;
            tx_data_d = in_data;
            eof_d     = in_eof;
            sum_d     = sum_q + in_data;
            len_d     = len_q + 16'd1;
            tx_rdy_d  = 1'b1;
          end
        end else if (tx_ack) begin
          if (eof_q || (len_q == MAX_LEN)) begin
            state_d   = CHECKSUM;
            tx_data_d = -sum_q;
            tx_rdy_d  = 1'b1;
            len_err_d = len_err_q | ~eof_q;
          end else begin
            tx_rdy_d = 1'b0;
          end
        end
      end
      CHECKSUM: begin
        if (tx_ack) begin
          state_d     = IDLE;
          tx_rdy_d    = 1'b0;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_data     = tx_data_q;
  assign tx_rdy      = tx_rdy_q;
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_cnt_q;
  assign len_err     = len_err_q;

endmodule

// File: tb/tb_tx_framer.sv
// Randomized bench for tx_framer: a frame-level model turns the pushed source
// bytes into the expected tx byte stream, frame count and length-error flag.
module tb_tx_framer;

  localparam int         MAXL = 4;
  localparam logic [7:0] SOF  = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_rdy;
  logic        in_eof;
  logic        in_ack;
  logic [7:0]  tx_data;
  logic        tx_rdy;
  logic        tx_ack;
  logic        busy;
  logic [15:0] frame_count;
  logic        len_err;

  tx_framer #(
    .DATA_WIDTH (8),
    .SOF_BYTE   (SOF),
    .MAX_LEN    (16'(MAXL))
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_rdy      (in_rdy),
    .in_eof      (in_eof),
    .in_ack      (in_ack),
    .tx_data     (tx_data),
    .tx_rdy      (tx_rdy),
    .tx_ack      (tx_ack),
    .busy        (busy),
    .frame_count (frame_count),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: source queue {eof,data}, expected tx queue {last,byte}.
  logic [8:0]  src_q[$];
  logic [8:0]  exp_q[$];
  logic [7:0]  m_frame[$];
  logic [15:0] m_frames;
  logic        m_len_err;
  int unsigned m_acks;
  int unsigned got_acks;

  // Sink/source handshake state of the bench.
  bit          presenting;
  bit          pending;
  bit          gap_chk;
  logic [7:0]  held;
  int unsigned wait_cnt;

  task automatic model_reset();
    src_q.delete();
    exp_q.delete();
    m_frame.delete();
    m_frames   = '0;
    m_len_err  = 1'b0;
    m_acks     = 0;
    got_acks   = 0;
    presenting = 0;
    pending    = 0;
    gap_chk    = 0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic eof);
    logic [7:0] s;
    src_q.push_back({eof, d});
    m_acks++;
    m_frame.push_back(d);
    if (eof || m_frame.size() == MAXL) begin
      s = 8'h00;
      exp_q.push_back({1'b0, SOF});
      foreach (m_frame[i]) begin
        exp_q.push_back({1'b0, m_frame[i]});
        s = s + m_frame[i];
      end
      exp_q.push_back({1'b1, 8'h00 - s});
      m_frames = m_frames + 16'd1;
      if (!eof) m_len_err = 1'b1;
      m_frame.delete();
    end
  endtask

  task automatic push_random_frame(input int unsigned len);
    for (int unsigned i = 0; i < len; i++)
      push_byte(8'($urandom), i == len - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    in_rdy  = 1'b1;
    in_eof  = 1'b1;
    in_data = 8'h5A;
    tx_ack  = 1'b1;
    #1 check("in_ack_during_rst", in_ack, 0);
    @(negedge clk);
    rst     = 1'b0;
    in_rdy  = 1'b0;
    in_eof  = 1'b0;
    in_data = 8'h00;
    tx_ack  = 1'b0;
    check("rst_tx_rdy", tx_rdy, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_len_err", len_err, 0);
    #1 check("rst_in_ack", in_ack, 0);
    model_reset();
  endtask

  // Drives the pushed source bytes through the DUT with a randomly delayed
  // sink. abort_at != 0 returns right after the sink acks that many bytes.
  task automatic run(input int unsigned dmin, input int unsigned dmax,
                     input bit spur, input int unsigned abort_at);
    logic [8:0]  e;
    int unsigned rx;
    int unsigned quiet;
    bit          done;
    rx = 0; quiet = 0; done = 0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      if (gap_chk) begin
        check("idle_gap_busy", busy, 0);
        gap_chk = 0;
      end
      if (tx_rdy) begin
        if (pending) check("tx_data_hold", tx_data, held);
        else begin
          pending  = 1;
          held     = tx_data;
          wait_cnt = $urandom_range(dmax, dmin);
        end
      end else if (pending) begin
        check("tx_rdy_hold", tx_rdy, 1);
        pending = 0;
      end
      tx_ack = 1'b0;
      if (pending) begin
        if (wait_cnt == 0) tx_ack = 1'b1;
        else wait_cnt--;
      end else if (spur) begin
        tx_ack = ($urandom_range(2, 0) == 0);
      end
      if (!presenting && src_q.size() > 0 && $urandom_range(3, 0) != 0) presenting = 1;
      in_rdy = presenting;
      if (presenting) begin
        in_data = src_q[0][7:0];
        in_eof  = src_q[0][8];
      end else begin
        in_data = 8'($urandom);
        in_eof  = 1'($urandom);
      end
      #1;
      if (in_ack) begin
        check("in_ack_vs_tx_rdy", tx_rdy, 0);
        check("in_ack_vs_in_rdy", in_rdy, 1);
        if (presenting) begin
          void'(src_q.pop_front());
          got_acks++;
          presenting = 0;
        end
      end
      if (tx_ack && pending) begin
        if (exp_q.size() == 0) check("extra_tx_byte", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check("tx_byte", tx_data, e[7:0]);
          gap_chk = e[8];
        end
        pending = 0;
        rx++;
        if (abort_at != 0 && rx == abort_at) done = 1;
      end
      if (src_q.size() == 0 && exp_q.size() == 0 && !pending) quiet++;
      else quiet = 0;
      if (quiet >= 3) done = 1;
    end
    if (!done) check("run_timeout", quiet, 3);
    if (abort_at == 0) begin
      check("frame_count", frame_count, m_frames);
      check("len_err", len_err, m_len_err);
      check("in_ack_count", got_acks, m_acks);
      check("end_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; in_rdy = 1'b0; in_eof = 1'b0; in_data = 8'h00; tx_ack = 1'b0;
    model_reset();
    do_reset();

    // 01 02 03 with immediate sink acks
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    push_byte(8'h03, 1'b1);
    run(0, 0, 0, 0);

    // three single-byte FF frames back to back
    repeat (3) push_byte(8'hFF, 1'b1);
    run(0, 0, 0, 0);

    // slow sink: 10 cycles per byte
    push_random_frame(3);
    run(10, 10, 0, 0);

    // truncation at MAX_LEN: 10..15, eof on 15
    for (int unsigned b = 8'h10; b <= 8'h15; b++)
      push_byte(8'(b), b == 8'h15);
    run(0, 2, 0, 0);

    // reset after the second payload byte of a 5-byte frame
    do_reset();
    for (int unsigned b = 8'h20; b <= 8'h24; b++)
      push_byte(8'(b), b == 8'h24);
    run(0, 1, 0, 3);
    do_reset();
    push_byte(8'h07, 1'b1);
    run(0, 0, 0, 0);

    // spurious sink acks while nothing is offered
    push_random_frame(2);
    push_random_frame(5);
    run(0, 3, 1, 0);
    repeat (6) begin
      @(negedge clk);
      check("idle_spur_tx_rdy", tx_rdy, 0);
      check("idle_spur_busy", busy, 0);
      in_rdy = 1'b0;
      tx_ack = ~tx_ack;
    end

    // random frames, lengths straddling MAX_LEN
    for (int k = 0; k < 20; k++)
      push_random_frame($urandom_range(9, 1));
    run(0, 4, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
